// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port memory between instruction fetch
// and load/store, holding each access stable for MEM_LAT cycles.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [63:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [63:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [63:0] ls_addr_i,
  input  logic [63:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [63:0] ls_rdata_o,
  output logic [63:0] mem_addr_o,
  output logic [63:0] mem_wdata_o,
  output logic        mem_we_o,
  input  logic [63:0] mem_rdata_i
);

  localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);
  localparam logic       ID_IF    = 1'b0;
  localparam logic       ID_LS    = 1'b1;

  typedef enum logic {S_IDLE, S_ACCESS} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic        we_q, we_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic        if_rvalid_q, if_rvalid_d;
  logic        ls_rvalid_q, ls_rvalid_d;
  logic [63:0] if_rdata_q, if_rdata_d;
  logic [63:0] ls_rdata_q, ls_rdata_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_rvalid_d = 1'b0;
    ls_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_gnt_o    = 1'b0;
    ls_gnt_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_we_o    = 1'b0;
    case (state_q)
      S_IDLE: begin
        // Grants are suppressed under reset so no requester sees an accept that is then lost.
        if (!rst_i && (if_req_i || ls_req_i)) begin
          if (ls_req_i && (!if_req_i || last_q == ID_IF)) begin
            ls_gnt_o = 1'b1;
            owner_d  = ID_LS;
            we_d     = ls_we_i;
            addr_d   = ls_addr_i;
            wdata_d  = ls_wdata_i;
          end else begin
            if_gnt_o = 1'b1;
            owner_d  = ID_IF;
            we_d     = 1'b0;
            addr_d   = if_addr_i;
            wdata_d  = '0;
          end
          last_d  = owner_d;
          state_d = S_ACCESS;
          cnt_d   = '0;
        end
      end
      S_ACCESS: begin
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        mem_we_o    = !rst_i && we_q && (cnt_q == CNT_LAST);
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (owner_q == ID_LS) begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = we_q ? 64'd0 : mem_rdata_i;
          end else begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_q      <= ID_IF;
      owner_q     <= ID_IF;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_rvalid_q <= if_rvalid_d;
      ls_rvalid_q <= ls_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign if_rvalid_o = if_rvalid_q;
  assign ls_rvalid_o = ls_rvalid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_rdata_o  = ls_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (MEM_LAT 2, 3, 1), one active at a time,
// sharing a small memory model and a grant-to-rvalid scoreboard.
module tb_mem_arbiter;

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic        rst, preload;
  logic [1:0]  sel;
  logic        if_req, ls_req, ls_we;
  logic [63:0] if_addr, ls_addr, ls_wdata, mem_rdata;

  logic [2:0]        rst_v, if_gnt_v, ls_gnt_v, if_rv_v, ls_rv_v, mem_we_v;
  logic [2:0][63:0]  if_rdata_v, ls_rdata_v, mem_addr_v, mem_wdata_v;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_arbiter #(.MEM_LAT(g == 0 ? 2 : (g == 1 ? 3 : 1))) u_dut (
      .clk_i       (gclk),
      .rst_i       (rst_v[g]),
      .if_req_i    (if_req),
      .if_addr_i   (if_addr),
      .if_gnt_o    (if_gnt_v[g]),
      .if_rvalid_o (if_rv_v[g]),
      .if_rdata_o  (if_rdata_v[g]),
      .ls_req_i    (ls_req),
      .ls_we_i     (ls_we),
      .ls_addr_i   (ls_addr),
      .ls_wdata_i  (ls_wdata),
      .ls_gnt_o    (ls_gnt_v[g]),
      .ls_rvalid_o (ls_rv_v[g]),
      .ls_rdata_o  (ls_rdata_v[g]),
      .mem_addr_o  (mem_addr_v[g]),
      .mem_wdata_o (mem_wdata_v[g]),
      .mem_we_o    (mem_we_v[g]),
      .mem_rdata_i (mem_rdata)
    );
  end

  // Inactive instances sit in reset.
  always_comb begin
    rst_v      = '1;
    rst_v[sel] = rst;
  end

  logic        if_gnt, ls_gnt, if_rv, ls_rv, mem_we;
  logic [63:0] if_rdata, ls_rdata, mem_addr, mem_wdata;
  assign if_gnt    = if_gnt_v[sel];
  assign ls_gnt    = ls_gnt_v[sel];
  assign if_rv     = if_rv_v[sel];
  assign ls_rv     = ls_rv_v[sel];
  assign mem_we    = mem_we_v[sel];
  assign if_rdata  = if_rdata_v[sel];
  assign ls_rdata  = ls_rdata_v[sel];
  assign mem_addr  = mem_addr_v[sel];
  assign mem_wdata = mem_wdata_v[sel];

  logic [63:0] mem [16];
  assign mem_rdata = mem[mem_addr[3:0]];
  always @(posedge gclk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) mem[i] <= (i == 5) ? 64'h1234 : 64'hA000 + 64'(i);
    end else if (mem_we) begin
      mem[mem_addr[3:0]] <= mem_wdata;
    end
  end

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge gclk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input logic [1:0] s);
    return (s == 2'd0) ? 2 : ((s == 2'd1) ? 3 : 1);
  endfunction

  typedef struct {
    logic        ls;
    logic [63:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always @(negedge gclk) begin
    if (if_rv || ls_rv) begin
      chk("rv_excl", 64'(if_rv & ls_rv), 64'd0);
      if (sb.size() == 0) begin
        chk("rv_unexpected", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rv_owner", 64'(ls_rv), 64'(mon_e.ls));
        chk("rv_data", ls_rv ? ls_rdata : if_rdata, mon_e.data);
        chk("rv_cycle", 64'(cyc), 64'(mon_e.due));
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      chk("rv_missing", 64'd0, 64'd1);
      void'(sb.pop_front());
    end
    if (if_gnt || ls_gnt) begin
      chk("gnt_excl", 64'(if_gnt & ls_gnt), 64'd0);
      mon_e.ls   = ls_gnt;
      mon_e.data = (ls_gnt && ls_we) ? 64'd0 : mem[ls_gnt ? ls_addr[3:0] : if_addr[3:0]];
      mon_e.due  = cyc + lat_of(sel) + 1;
      sb.push_back(mon_e);
    end
    if (rst) sb.delete();
  end

  task automatic tick();
    @(posedge gclk);
    #1;
  endtask

  task automatic smp();
    @(negedge gclk);
  endtask

  task automatic restart(input logic [1:0] s);
    rst = 1'b1;
    sel = s;
    tick();
    smp();
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_flags", 64'({if_rv, ls_rv, mem_we}), 64'd0);
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 6; i++) tick();
    smp();
    chk(tag, 64'(sb.size()), 64'd0);
    tick();
  endtask

  int wcnt, wcyc, ngnt, lastc;
  logic bad;

  initial begin
    rst = 1'b1; preload = 1'b1; sel = 2'd0;
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    if_addr = '0; ls_addr = '0; ls_wdata = '0;
    tick();
    preload = 1'b0;
    restart(2'd0);

    // single IF read of word 5
    if_req = 1'b1; if_addr = 64'd5;
    smp(); chk("t1_gnt", 64'(if_gnt), 64'd1);
    tick(); if_req = 1'b0; if_addr = '0;
    smp(); chk("t1_addr1", mem_addr, 64'd5); tick();
    smp(); chk("t1_addr2", mem_addr, 64'd5); tick();
    smp(); chk("t1_rv", 64'(if_rv), 64'd1); chk("t1_rdata", if_rdata, 64'h1234); tick();
    smp(); chk("t1_rv_end", 64'(if_rv), 64'd0); tick();

    // LS write then read back
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'd7; ls_wdata = 64'hDEAD;
    smp(); chk("t2_gnt", 64'(ls_gnt), 64'd1);
    tick(); ls_req = 1'b0; ls_we = 1'b0; ls_wdata = '0;
    wcnt = 0; wcyc = -1;
    for (int i = 0; i < 3; i++) begin
      smp();
      if (mem_we) begin wcnt++; wcyc = i; end
      if (i == 2) begin
        chk("t2_rv", 64'(ls_rv), 64'd1);
        chk("t2_rdata", ls_rdata, 64'd0);
      end
      tick();
    end
    chk("t2_we_cnt", 64'(wcnt), 64'd1);
    chk("t2_we_cyc", 64'(wcyc), 64'd1);
    ls_req = 1'b1; ls_addr = 64'd7;
    smp(); chk("t2_rd_gnt", 64'(ls_gnt), 64'd1);
    tick(); ls_req = 1'b0;
    tick(); tick();
    smp(); chk("t2_rd_rv", 64'(ls_rv), 64'd1); chk("t2_rd_data", ls_rdata, 64'hDEAD);
    tick();

    // contention held from reset
    if_req = 1'b1; ls_req = 1'b1; if_addr = 64'd1; ls_addr = 64'd2;
    restart(2'd0);
    ngnt = 0; lastc = 0;
    for (int i = 0; i < 13; i++) begin
      smp();
      if (if_gnt || ls_gnt) begin
        chk("t3_order", 64'(ls_gnt), 64'(ngnt % 2 == 0));
        if (ngnt > 0) chk("t3_space", 64'(cyc - lastc), 64'd3);
        lastc = cyc;
        ngnt++;
      end
      tick();
    end
    chk("t3_ngnt", 64'(ngnt), 64'd5);
    if_req = 1'b0; ls_req = 1'b0;
    drain("t3_drain");

    // IF back-to-back: new grant in the rvalid cycle
    if_req = 1'b1; if_addr = 64'd3;
    smp(); chk("t4_gnt", 64'(if_gnt), 64'd1);
    tick(); tick(); tick();
    smp(); chk("t4_rv", 64'(if_rv), 64'd1); chk("t4_gnt2", 64'(if_gnt), 64'd1);
    tick(); if_req = 1'b0;
    drain("t4_drain");

    // reset during an LS write, MEM_LAT = 3
    restart(2'd1);
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'd9; ls_wdata = 64'hBEEF;
    smp(); chk("t5_gnt", 64'(ls_gnt), 64'd1);
    tick(); ls_req = 1'b0; ls_we = 1'b0; rst = 1'b1;
    bad = 1'b0;
    smp(); bad = bad | mem_we;
    tick(); rst = 1'b0;
    smp();
    chk("t5_zero_addr", mem_addr, 64'd0);
    chk("t5_zero_flags", 64'({if_rv, ls_rv, mem_we, if_gnt, ls_gnt}), 64'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      smp(); bad = bad | mem_we | if_rv | ls_rv;
      tick();
    end
    chk("t5_quiet", 64'(bad), 64'd0);
    chk("t5_mem9", mem[9], 64'hA009);
    if_req = 1'b1; ls_req = 1'b1; if_addr = 64'd4; ls_addr = 64'd6;
    smp(); chk("t5_tie_ls", 64'(ls_gnt), 64'd1); chk("t5_tie_if", 64'(if_gnt), 64'd0);
    tick(); if_req = 1'b0; ls_req = 1'b0;
    drain("t5_drain");

    // MEM_LAT = 1 read of word 0, we toggled mid-access
    restart(2'd2);
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 64'd0;
    smp(); chk("t6_gnt", 64'(ls_gnt), 64'd1);
    tick(); ls_req = 1'b0; ls_we = 1'b1; ls_wdata = 64'hFFFF;
    smp(); chk("t6_we", 64'(mem_we), 64'd0); chk("t6_rv_early", 64'(ls_rv), 64'd0);
    tick(); ls_we = 1'b0; ls_wdata = '0;
    smp(); chk("t6_rv", 64'(ls_rv), 64'd1); chk("t6_rdata", ls_rdata, 64'hA000);
    tick();
    drain("t6_drain");
    chk("t6_mem0", mem[0], 64'hA000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
